// File: rtl/intersection_phase_ctrl.sv
// Traffic-light phase sequencer for a two-way intersection with a pedestrian
// walk phase inserted after an all-red clearance whenever a request is latched.
module intersection_phase_ctrl #(
  parameter int GREEN_TICKS  = 15,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  output logic [2:0] phase,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       walk,
  output logic       ped_ack,
  output logic       ped_pending,
  output logic [7:0] timer_value
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR_NS = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR_EW = 3'd5,
    WALK  = 3'd6,
    BAD   = 3'd7
  } phase_t;

  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_RED    = 2'b10;

  // Timer reload values: a phase of N ticks counts N-1 down to 0.
  localparam logic [7:0] L_GREEN  = 8'(GREEN_TICKS - 1);
  localparam logic [7:0] L_YELLOW = 8'(YELLOW_TICKS - 1);
  localparam logic [7:0] L_ALLRED = 8'(ALLRED_TICKS - 1);
  localparam logic [7:0] L_WALK   = 8'(WALK_TICKS - 1);

  phase_t     r_phase;
  logic [7:0] r_timer;
  logic       r_pending;
  logic       r_ack;
  logic       r_dir_ew;   // 1: walk resumes into EW_G, 0: into NS_G

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase   <= AR_EW;
      r_timer   <= L_ALLRED;
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
      r_dir_ew  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (ped_req && r_phase != WALK)
        r_pending <= 1'b1;

      if (r_phase == BAD) begin
        r_phase <= AR_EW;
        r_timer <= L_ALLRED;
      end else if (tick) begin
        if (r_timer != 8'd0) begin
          r_timer <= r_timer - 8'd1;
        end else begin
          // Walk entry clears the request; this later assignment wins over the set above.
          case (r_phase)
            NS_G: begin
              r_phase <= NS_Y;
              r_timer <= L_YELLOW;
            end
            NS_Y: begin
              r_phase <= AR_NS;
              r_timer <= L_ALLRED;
            end
            AR_NS: begin
              if (r_pending) begin
                r_phase   <= WALK;
                r_timer   <= L_WALK;
                r_dir_ew  <= 1'b1;
                r_pending <= 1'b0;
                r_ack     <= 1'b1;
              end else begin
                r_phase <= EW_G;
                r_timer <= L_GREEN;
              end
            end
            EW_G: begin
              r_phase <= EW_Y;
              r_timer <= L_YELLOW;
            end
            EW_Y: begin
              r_phase <= AR_EW;
              r_timer <= L_ALLRED;
            end
            AR_EW: begin
              if (r_pending) begin
                r_phase   <= WALK;
                r_timer   <= L_WALK;
                r_dir_ew  <= 1'b0;
                r_pending <= 1'b0;
                r_ack     <= 1'b1;
              end else begin
                r_phase <= NS_G;
                r_timer <= L_GREEN;
              end
            end
            WALK: begin
              r_phase <= r_dir_ew ? EW_G : NS_G;
              r_timer <= L_GREEN;
            end
            default: begin
              r_phase <= AR_EW;
              r_timer <= L_ALLRED;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    walk     = 1'b0;
    case (r_phase)
      NS_G:    ns_light = LAMP_GREEN;
      NS_Y:    ns_light = LAMP_YELLOW;
      EW_G:    ew_light = LAMP_GREEN;
      EW_Y:    ew_light = LAMP_YELLOW;
      WALK:    walk     = 1'b1;
      default: ;
    endcase
  end

  assign phase       = r_phase;
  assign timer_value = r_timer;
  assign ped_pending = r_pending;
  assign ped_ack     = r_ack;

endmodule

// File: tb/tb_intersection_phase_ctrl.sv
// Self-checking bench: directed scenarios plus random stimulus, compared every
// cycle against a phase/elapsed-tick model of the intersection rules.
module tb_intersection_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] phase;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       walk;
  logic       ped_ack;
  logic       ped_pending;
  logic [7:0] timer_value;

  intersection_phase_ctrl #(
    .GREEN_TICKS(4), .YELLOW_TICKS(2), .ALLRED_TICKS(1), .WALK_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req),
    .phase(phase), .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
    .ped_ack(ped_ack), .ped_pending(ped_pending), .timer_value(timer_value)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: phase, ticks already spent in it, latched request, resume direction.
  int dur [7] = '{4, 2, 1, 4, 2, 1, 3};
  int m_phase = 5;
  int m_elapsed = 0;
  int m_pend = 0;
  int m_ack = 0;
  int m_resume = 0;

  function automatic int m_timer();
    return dur[m_phase] - 1 - m_elapsed;
  endfunction

  function automatic int lamp_ns(int p);
    return (p == 0) ? 0 : (p == 1) ? 1 : 2;
  endfunction

  function automatic int lamp_ew(int p);
    return (p == 3) ? 0 : (p == 4) ? 1 : 2;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit t, input bit q);
    int nxt;
    bit entered;
    if (r) begin
      m_phase = 5; m_elapsed = 0; m_pend = 0; m_ack = 0; m_resume = 0;
      return;
    end
    entered = 1'b0;
    if (t) begin
      if (m_elapsed == dur[m_phase] - 1) begin
        nxt = (m_phase + 1) % 6;
        if (m_phase == 6) nxt = m_resume;
        else if ((m_phase == 2 || m_phase == 5) && m_pend != 0) begin
          m_resume = (m_phase == 2) ? 3 : 0;
          nxt = 6;
          entered = 1'b1;
        end
        m_phase = nxt;
        m_elapsed = 0;
      end else begin
        m_elapsed++;
      end
    end
    if (entered) m_pend = 0;
    else if (q && m_phase != 6) m_pend = 1;
    m_ack = entered ? 1 : 0;
  endtask

  // Inputs change only at the falling edge; the model advances with the DUT.
  task automatic cyc(input bit r, input bit t, input bit q);
    bit was_walk;
    rst = r; tick = t; ped_req = q;
    @(posedge clk);
    was_walk = (m_phase == 6);
    // A request seen while in WALK is ignored, judged on the pre-edge phase.
    model_step(r, t, q && !was_walk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("phase", int'(phase), m_phase);
      chk("timer_value", int'(timer_value), m_timer());
      chk("ns_light", int'(ns_light), lamp_ns(m_phase));
      chk("ew_light", int'(ew_light), lamp_ew(m_phase));
      chk("walk", int'(walk), (m_phase == 6) ? 1 : 0);
      chk("ped_pending", int'(ped_pending), m_pend);
      chk("ped_ack", int'(ped_ack), m_ack);
      chk("lamp_conflict", int'(ns_light != 2'b10 && ew_light != 2'b10), 0);
    end
  end

  task automatic run_to(input int ph, input int tv, input bit q);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_phase == ph && m_timer() == tv) begin
        ok = 1'b1;
        break;
      end
      cyc(1'b0, 1'b1, q);
    end
    chk("run_to_timeout", int'(ok), 1);
  endtask

  int acks;
  int walks;

  initial begin
    // Reset with tick high, then the first green must be NS_G.
    chk_en = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    chk("rst_phase", int'(phase), 5);
    chk("rst_timer", int'(timer_value), 0);
    chk("rst_lamps", int'({ns_light, ew_light}), 4'b1010);
    cyc(1'b0, 1'b1, 1'b0);
    chk("first_green", int'(phase), 0);
    chk("first_timer", int'(timer_value), 3);
    chk("first_ns", int'(ns_light), 0);
    chk("first_ew", int'(ew_light), 2);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("ns_g_lasts_4", int'(phase), 1);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("period_14", int'(phase), 1);

    // Tick stall in EW_G with two ticks remaining after this one.
    run_to(3, 2, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("stall_phase", int'(phase), 3);
    chk("stall_timer", int'(timer_value), 2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("resume_ew_y", int'(phase), 4);

    // One-cycle request during NS_G.
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("req_latched", int'(ped_pending), 1);
    acks = 0; walks = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      acks += int'(ped_ack);
      walks += int'(walk);
    end
    chk("ack_count", acks, 1);
    chk("walk_cycles", walks, 3);

    // Request on the very cycle WALK is entered, then reset inside WALK.
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    run_to(2, 0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("walk_entry_phase", int'(phase), 6);
    chk("walk_entry_pending", int'(ped_pending), 0);
    chk("walk_entry_ack", int'(ped_ack), 1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("walk_timer1", int'(timer_value), 1);
    chk("pending_stays_0", int'(ped_pending), 0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("walk_rst_phase", int'(phase), 5);
    chk("walk_rst_walk", int'(walk), 0);
    chk("walk_rst_pending", int'(ped_pending), 0);
    chk("walk_rst_timer", int'(timer_value), 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("after_rst_green", int'(phase), 0);

    // Held request: a walk after every clearance.
    walks = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      walks += int'(ped_ack);
    end
    chk("held_req_walks", walks, 4);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(199) == 0), ($urandom_range(9) < 7), ($urandom_range(9) == 0));

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/intersection_phase_ctrl.md
INTERSECTION_PHASE_CTRL -- requirements
Module: intersection_phase_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- GREEN_TICKS, 15, green duration in ticks, 1..255.
- YELLOW_TICKS, 3, yellow duration in ticks, 1..255.
- ALLRED_TICKS, 2, all-red clearance duration in ticks, 1..255.
- WALK_TICKS, 10, pedestrian walk duration in ticks, 1..255.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- tick, in, 1, one-cycle time-base enable.
- ped_req, in, 1, pedestrian request, level or pulse.
- phase, out, 3, current phase code.
- ns_light, out, 2, north-south lamp.
- ew_light, out, 2, east-west lamp.
- walk, out, 1, pedestrian walk lamp.
- ped_ack, out, 1, one-cycle pulse when a walk phase starts.
- ped_pending, out, 1, request latched, not yet served.
- timer_value, out, 8, remaining ticks minus one in the current phase.

REQ-003 Lamp encoding SHALL be 2'b00 GREEN, 2'b01 YELLOW, 2'b10 RED; 2'b11 SHALL never be driven.

Function
REQ-004 Phase codes SHALL be: 0 NS_G, 1 NS_Y, 2 AR_NS, 3 EW_G, 4 EW_Y, 5 AR_EW, 6 WALK; code 7 SHALL be unreachable, and if it is ever reached the block SHALL recover to AR_EW on the next clock.

REQ-005 The phase sequence SHALL be NS_G -> NS_Y -> AR_NS -> EW_G -> EW_Y -> AR_EW -> NS_G.

REQ-006 When leaving AR_NS or AR_EW with ped_pending=1, the next phase SHALL be WALK instead of the next green.

REQ-007 On leaving WALK, the next phase SHALL be the green that was skipped: EW_G if WALK followed AR_NS, NS_G if it followed AR_EW. This choice SHALL be held in an internal direction register.

REQ-008 Lamp decode SHALL be combinational from the phase register, with zero latency:
- ns_light: GREEN in NS_G, YELLOW in NS_Y, RED otherwise.
- ew_light: GREEN in EW_G, YELLOW in EW_Y, RED otherwise.
- walk: 1 only in WALK.

REQ-009 Timer update on a cycle with tick=1:
- timer_value != 0: decrement by 1.
- timer_value == 0: advance to the next phase and load that phase's duration minus 1.

REQ-010 On a cycle with tick=0, phase and timer_value SHALL hold.

REQ-011 Each phase SHALL therefore last exactly its parameter count of ticks.

REQ-012 ped_pending SHALL set on any cycle with ped_req=1, except as given in REQ-013.

REQ-013 ped_pending SHALL clear on the cycle the phase register enters WALK. Clear SHALL win over a simultaneous ped_req. ped_req asserted while phase is WALK SHALL be ignored.

REQ-014 ped_ack SHALL be registered and equal 1 for exactly the first clock cycle in which phase equals WALK, and 0 otherwise.

REQ-015 A ped_req arriving during AR_NS or AR_EW before its final tick SHALL be served at that clearance's exit.

REQ-016 Vehicle lamps SHALL never show non-RED on both directions at once.

REQ-017 walk=1 SHALL imply ns_light=ew_light=RED.

Reset
REQ-018 While rst=1 at a clock edge, the next state SHALL be:
- phase=AR_EW (5), timer_value=ALLRED_TICKS-1.
- ped_pending=0, ped_ack=0, direction register pointing to NS_G.
- Result: ns_light=ew_light=RED, walk=0.

REQ-019 rst SHALL take priority over tick and ped_req. Reset asserted mid-phase, including WALK, SHALL abort that phase immediately and discard pending requests.

REQ-020 The first green after reset SHALL be NS_G.

Verification
All scenarios use GREEN=4, YELLOW=2, ALLRED=1, WALK=3.

REQ-021 Reset, then tick=1 every cycle -> after the first clock, phase=5 with both lamps RED; the next cycle gives phase=0, timer_value=3, ns_light=00, ew_light=10.

REQ-022 No ped_req, tick every cycle -> the NS_G..AR_EW cycle repeats with period 14 clocks. Per-phase cycle counts SHALL be 4, 2, 1, 4, 2, 1. Both lamps SHALL never be non-RED together.

REQ-023 One-cycle ped_req during NS_G -> ped_pending=1 until WALK entry. The sequence SHALL be NS_Y(2), AR_NS(1), WALK(3) with walk=1 and ped_ack high one cycle, then EW_G. ped_pending=0 from WALK entry onward.

REQ-024 tick held 0 for 10 cycles in EW_G with timer_value=2 -> phase=3 and timer_value=2 are unchanged. Resuming ticks -> 3 ticks to EW_Y.

REQ-025 Boundary requests:
- ped_req asserted on the same cycle phase enters WALK -> ped_pending stays 0 afterwards.
- ped_req held continuously -> WALK occurs after every clearance phase.

REQ-026 rst pulsed for one cycle while in WALK with timer_value=1 -> phase=5, walk=0, ped_pending=0, timer_value=0. The next tick gives NS_G.
